alu_ctrl: RTL and testbench
===========================

# alu_ctrl

Sequencing controller wrapped around the CPU's 32-bit integer ALU datapath. It accepts one operation at a time over a valid/ready request channel and computes the selected result. It keeps the architectural carry flag between operations. The result goes out on a valid/ready response channel, one beat for scalar ops and two beats (low, then high) for MUL. It sits between the CPU execute stage and the combinational ALU and owns all ALU state.

## Interface
- `TAG_W`, default 4: width of the opaque request tag echoed on the response.
- `clk`, input, 1: sole clock; all state on rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req_valid`, input, 1: request present.
- `req_ready`, output, 1: controller can accept a request this cycle.
- `req_op`, input, 4: opcode; encoding is in the package.
- `req_a`, input, 32: operand A.
- `req_b`, input, 32: operand B (shift amount for shifts).
- `req_tag`, input, TAG_W: tag echoed on every response beat.
- `rsp_valid`, output, 1: response beat present.
- `rsp_ready`, input, 1: consumer accepts the beat.
- `rsp_data`, output, 32: result beat.
- `rsp_tag`, output, TAG_W: tag of the owning request.
- `rsp_last`, output, 1: final beat of this request.
- `rsp_err`, output, 1: the opcode was illegal.
- `carry_flag`, output, 1: registered architectural carry.
- `flag_clr`, input, 1: synchronous clear of `carry_flag`.

## Operation
- **Opcodes:**
  - 0 ADD = a+b
  - 1 ADC = a+b+carry_flag
  - 2 SUB = a−b
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 NOT = ~a
  - 7 SHL
  - 8 SHR (logical)
  - 9 SAR
  - 10 REV (bit-reverse of a)
  - 11 MUL (signed 32×32 → 64)
  - 12–15 illegal
- **Shifts:** amount is unsigned b[31:0].
  - Amount ≥32 gives 0 for SHL and SHR.
  - Amount ≥32 gives 32 copies of a[31] for SAR.
- **Carry update:** the flag updates only on acceptance of ADD, ADC or SUB.
  - ADD/ADC: flag ← bit 32 of the 33-bit unsigned sum.
  - SUB: flag ← (a ≥ b unsigned), i.e. not-borrow.
  - All other ops leave the flag unchanged.
- **ADC uses the pre-edge flag:** ADC reads the registered flag value from before the acceptance edge.
- **flag_clr vs. update:** `flag_clr` clears the flag unless a carry-updating op is accepted in the same cycle; in that case the op's update wins.
- **Illegal opcode:** produces one beat with `rsp_data`=0, `rsp_err`=1, `rsp_last`=1, and no flag change.
- **States:**
  - IDLE: go to RESP on accept of a non-MUL op; go to MUL_LO on accept of MUL.
  - RESP: presents the single beat with last=1.
  - MUL_LO: presents product[31:0] with last=0; goes to MUL_HI on handshake.
  - MUL_HI: presents product[63:32] with last=1.
- **On the last-beat handshake:** the FSM goes to the new request's state if one is accepted the same cycle, otherwise to IDLE.
- **req_ready** = (state==IDLE) | (rsp_valid & rsp_ready & rsp_last). Back-to-back ops therefore run without a bubble.
- **Response hold:** `rsp_data`, `rsp_tag`, `rsp_err` and `rsp_last` stay stable while `rsp_valid` & !`rsp_ready`.
- **Registered results:** result registers hold the full 64-bit product. The response path has no combinational dependence on the `req_*` inputs.

## Timing
- **Reset values:** state=IDLE, `rsp_valid`=0, `rsp_data`=0, `rsp_tag`=0, `rsp_last`=0, `rsp_err`=0, `carry_flag`=0, and `req_ready`=1 once `rst` deasserts.
- **Latency:** request accepted at edge N → first beat valid in the cycle after edge N (1-cycle latency).
  - MUL high beat is valid no earlier than one cycle after the low-beat handshake.
- **Throughput:** one scalar op per cycle with `rsp_ready` held high; one MUL per 2 cycles.
- **Reset mid-operation:** asserting `rst` in any state discards the pending beats, returns to IDLE and clears the flag; no beat is emitted afterwards.
- **req_valid while busy:** `req_valid` while `req_ready`=0 is ignored; the requester must hold it.

## Structure
- **Package `alu_ctrl_pkg`:**
  - opcode enum `alu_op_e` (4 bits);
  - FSM enum `alu_st_e` {IDLE, RESP, MUL_LO, MUL_HI};
  - constant `ALU_W`=32.
- **Sub-module `alu_ctrl_core`:** purely combinational.
  - Inputs: op, a, b, carry-in.
  - Outputs: result[63:0], carry-out, flag-update enable, illegal.
  - The top holds the FSM, registers and flag.

## Test plan
1. **Reset then ADD:** ADD 0xFFFFFFFF+0x1, tag 3 → one beat: data 0x0, last=1, tag 3; then `carry_flag`=1.
2. **Chained ADC:** ADC 0x5+0x6 after test 1 → data 0xC, `carry_flag`=0. Then `flag_clr` held in the same cycle as an accepted SUB 5−3 → `carry_flag`=1 (op wins).
3. **MUL with backpressure:** MUL −2×3 with `rsp_ready` low 3 cycles → low beat 0xFFFFFFFA held stable (last=0), then high beat 0xFFFFFFFF (last=1).
4. **Shift edges:**
   - SHL 0x1 by 31 → 0x80000000.
   - SHR 0x80000000 by 40 → 0x0.
   - SAR 0x80000000 by 40 → 0xFFFFFFFF.
   - REV 0x1 → 0x80000000.
5. **Illegal and back-to-back:** op 13 → data 0, err=1, flag unchanged. Then 4 scalar ops with `rsp_ready`=1 throughout → 4 consecutive beats, no bubble, tags in order.
6. **Reset mid-MUL:** `rst` asserted in MUL_HI → `rsp_valid`=0 immediately, state IDLE, `carry_flag`=0, no high beat after release.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared types and constants for the ALU sequencing controller.
//   alu_op_e : 4-bit opcode encoding (12..15 are illegal)
//   alu_st_e : controller FSM states
//   ALU_W    : datapath width
package alu_ctrl_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_ADC = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_NOT = 4'd6,
    OP_SHL = 4'd7,
    OP_SHR = 4'd8,
    OP_SAR = 4'd9,
    OP_REV = 4'd10,
    OP_MUL = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP   = 2'd1,
    MUL_LO = 2'd2,
    MUL_HI = 2'd3
  } alu_st_e;

endpackage

// File: rtl/alu_ctrl_core.sv
// alu_ctrl_core: purely combinational ALU datapath.
//   op       : opcode
//   a, b     : operands (b is the unsigned shift amount for shifts)
//   cin      : carry-in (architectural carry flag) used by ADC
//   result   : 64-bit result; only MUL uses the upper half, else upper half is 0
//   cout     : carry-out / not-borrow for ADD, ADC, SUB
//   flag_we  : op updates the carry flag
//   illegal  : opcode is not defined
module alu_ctrl_core
  import alu_ctrl_pkg::*;
(
  input  alu_op_e            op,
  input  logic [ALU_W-1:0]   a,
  input  logic [ALU_W-1:0]   b,
  input  logic               cin,
  output logic [2*ALU_W-1:0] result,
  output logic               cout,
  output logic               flag_we,
  output logic               illegal
);

  logic [ALU_W:0]       sum_s;
  logic [ALU_W:0]       adc_s;
  logic [ALU_W-1:0]     rev_s;
  logic                 big_shift_s;
  logic signed [63:0]   prod_s;

  // 33-bit sums so the carry is simply the top bit
  assign sum_s = {1'b0, a} + {1'b0, b};
  assign adc_s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
  // Any amount bit above bit 4 means the shift is 32 or more
  assign big_shift_s = |b[ALU_W-1:5];
  // Operands sign-extended to 64 bits so the truncated product is the signed result
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

  // Bit reversal of operand A
  always_comb begin
    rev_s = {ALU_W{1'b0}};
    for (int i = 0; i < ALU_W; i++) begin
      rev_s[i] = a[ALU_W-1-i];
    end
  end

  // Opcode decode and result selection
  always_comb begin
    result  = {(2*ALU_W){1'b0}};
    cout    = 1'b0;
    flag_we = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_ADD: begin
        result[31:0] = sum_s[31:0];
        cout         = sum_s[32];
        flag_we      = 1'b1;
      end
      OP_ADC: begin
        result[31:0] = adc_s[31:0];
        cout         = adc_s[32];
        flag_we      = 1'b1;
      end
      OP_SUB: begin
        result[31:0] = a - b;
        cout         = (a >= b);
        flag_we      = 1'b1;
      end
      OP_AND: result[31:0] = a & b;
      OP_OR:  result[31:0] = a | b;
      OP_XOR: result[31:0] = a ^ b;
      OP_NOT: result[31:0] = ~a;
      OP_SHL: result[31:0] = big_shift_s ? 32'd0 : (a << b[4:0]);
      OP_SHR: result[31:0] = big_shift_s ? 32'd0 : (a >> b[4:0]);
      OP_SAR: result[31:0] = big_shift_s ? {32{a[31]}} : 32'($signed(a) >>> b[4:0]);
      OP_REV: result[31:0] = rev_s;
      OP_MUL: result       = prod_s;
      default: illegal     = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: sequencing controller around the combinational ALU.
//   clk, rst              : clock, async active-high reset
//   req_valid/ready       : request handshake; req_op/a/b/tag request payload
//   rsp_valid/ready       : response handshake; rsp_data/tag/last/err beat payload
//   carry_flag            : registered architectural carry
//   flag_clr              : synchronous clear of carry_flag (a carry-updating op wins)
// MUL returns two beats (low then high); every other op returns one.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [ALU_W-1:0] req_a,
  input  logic [ALU_W-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ALU_W-1:0] rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_last,
  output logic             rsp_err,
  output logic             carry_flag,
  input  logic             flag_clr
);

  alu_st_e            state_r;
  alu_st_e            state_nxt_s;
  logic [2*ALU_W-1:0] res_r;
  logic [TAG_W-1:0]   tag_r;
  logic               err_r;
  logic               last_r;
  logic               valid_r;
  logic               carry_r;

  logic [2*ALU_W-1:0] core_result_s;
  logic               core_cout_s;
  logic               core_flag_we_s;
  logic               core_illegal_s;
  logic               accept_s;
  logic               last_hs_s;
  logic               lo_hs_s;
  logic               is_mul_s;

  alu_ctrl_core u_core (
    .op      (alu_op_e'(req_op)),
    .a       (req_a),
    .b       (req_b),
    .cin     (carry_r),
    .result  (core_result_s),
    .cout    (core_cout_s),
    .flag_we (core_flag_we_s),
    .illegal (core_illegal_s)
  );

  // Handshake qualifiers; a new request may land on the same edge as the final beat
  assign last_hs_s = valid_r & rsp_ready & last_r;
  assign lo_hs_s   = valid_r & rsp_ready & ~last_r;
  assign req_ready = (state_r == IDLE) | last_hs_s;
  assign accept_s  = req_valid & req_ready;
  assign is_mul_s  = (req_op == OP_MUL);

  // Next-state selection
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = is_mul_s ? MUL_LO : RESP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL_LO: begin
        if (lo_hs_s) begin
          state_nxt_s = MUL_HI;
        end else begin
          state_nxt_s = MUL_LO;
        end
      end
      RESP, MUL_HI: begin
        if (last_hs_s && accept_s) begin
          state_nxt_s = is_mul_s ? MUL_LO : RESP;
        end else if (last_hs_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM, result capture and response beat registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      valid_r <= 1'b0;
      res_r   <= {(2*ALU_W){1'b0}};
      tag_r   <= {TAG_W{1'b0}};
      err_r   <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      valid_r <= (state_nxt_s != IDLE);
      if (accept_s) begin
        res_r  <= core_result_s;
        tag_r  <= req_tag;
        err_r  <= core_illegal_s;
        last_r <= ~is_mul_s;
      end else if (lo_hs_s) begin
        last_r <= 1'b1;
      end
    end
  end

  // Carry flag: an accepted carry-updating op takes priority over flag_clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_r <= 1'b0;
    end else if (accept_s && core_flag_we_s) begin
      carry_r <= core_cout_s;
    end else if (flag_clr) begin
      carry_r <= 1'b0;
    end
  end

  // Beat data selects from the registered 64-bit result only
  assign rsp_data   = (state_r == MUL_HI) ? res_r[63:32] : res_r[31:0];
  assign rsp_valid  = valid_r;
  assign rsp_tag    = tag_r;
  assign rsp_last   = last_r;
  assign rsp_err    = err_r;
  assign carry_flag = carry_r;

endmodule

// File: tb/tb_alu_ctrl.sv
module tb_alu_ctrl;
  import alu_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        rsp_last;
  logic        rsp_err;
  logic        carry_flag;
  logic        flag_clr;

  int checks = 0;
  int passed = 0;

  alu_ctrl #(.TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .carry_flag(carry_flag), .flag_clr(flag_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request and return #1 after the edge on which it is accepted
  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag);
    int n;
    n = 0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 50) $display("FAIL issue_timeout: req_ready never rose (op %0d)", op);
    else passed++;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rsp_valid); else passed++;
    checks++; if (rsp_data !== 32'd0) $display("FAIL reset_data: got %h want 0", rsp_data); else passed++;
    checks++; if ({rsp_tag, rsp_last, rsp_err} !== 6'd0) $display("FAIL reset_tag_last_err: got %b want 0", {rsp_tag, rsp_last, rsp_err}); else passed++;
    checks++; if (carry_flag !== 1'b0) $display("FAIL reset_carry: got %b want 0", carry_flag); else passed++;
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else passed++;
  endtask

  task automatic test_add();
    rsp_ready = 1'b1;
    issue(OP_ADD, 32'hFFFF_FFFF, 32'h1, 4'd3);
    checks++; if (rsp_valid !== 1'b1) $display("FAIL add_valid: got %b want 1", rsp_valid); else passed++;
    checks++; if (rsp_data !== 32'h0) $display("FAIL add_data: got %h want 00000000", rsp_data); else passed++;
    checks++; if (rsp_last !== 1'b1 || rsp_tag !== 4'd3) $display("FAIL add_last_tag: got last=%b tag=%0d want last=1 tag=3", rsp_last, rsp_tag); else passed++;
    checks++; if (carry_flag !== 1'b1) $display("FAIL add_carry: got %b want 1", carry_flag); else passed++;
  endtask

  task automatic test_adc_flag_clr();
    issue(OP_ADC, 32'h5, 32'h6, 4'd4);
    checks++; if (rsp_data !== 32'hC) $display("FAIL adc_data: got %h want 0000000c", rsp_data); else passed++;
    checks++; if (carry_flag !== 1'b0) $display("FAIL adc_carry: got %b want 0", carry_flag); else passed++;
    flag_clr = 1'b1;
    issue(OP_SUB, 32'h5, 32'h3, 4'd6);
    flag_clr = 1'b0;
    checks++; if (rsp_data !== 32'h2) $display("FAIL sub_data: got %h want 00000002", rsp_data); else passed++;
    checks++; if (carry_flag !== 1'b1) $display("FAIL sub_vs_clr_carry: got %b want 1", carry_flag); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_mul_backpressure();
    rsp_ready = 1'b0;
    issue(OP_MUL, 32'hFFFF_FFFE, 32'h3, 4'd5);
    checks++; if (rsp_valid !== 1'b1 || rsp_last !== 1'b0) $display("FAIL mul_lo_first: got valid=%b last=%b want 1/0", rsp_valid, rsp_last); else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFF_FFFA || rsp_last !== 1'b0 || rsp_tag !== 4'd5)
        $display("FAIL mul_lo_hold: cycle %0d got v=%b d=%h l=%b t=%0d want 1 fffffffa 0 5", i, rsp_valid, rsp_data, rsp_last, rsp_tag);
      else passed++;
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFF_FFFF || rsp_last !== 1'b1 || rsp_tag !== 4'd5)
      $display("FAIL mul_hi: got v=%b d=%h l=%b t=%0d want 1 ffffffff 1 5", rsp_valid, rsp_data, rsp_last, rsp_tag);
    else passed++;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL mul_done_valid: got %b want 0", rsp_valid); else passed++;
    checks++; if (carry_flag !== 1'b1) $display("FAIL mul_carry_kept: got %b want 1", carry_flag); else passed++;
  endtask

  task automatic test_shifts();
    logic [3:0]  ops [6];
    logic [31:0] as  [6];
    logic [31:0] bs  [6];
    logic [31:0] exp [6];
    ops = '{OP_SHL, OP_SHR, OP_SAR, OP_REV, OP_SHR, OP_SAR};
    as  = '{32'h1, 32'h8000_0000, 32'h8000_0000, 32'h1, 32'h8000_0000, 32'h4000_0000};
    bs  = '{32'd31, 32'd40, 32'd40, 32'd0, 32'd31, 32'd30};
    exp = '{32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1, 32'h1};
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], as[i], bs[i], 4'(i));
      checks++;
      if (rsp_data !== exp[i]) $display("FAIL shift_%0d: op %0d got %h want %h", i, ops[i], rsp_data, exp[i]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [4];
    logic [31:0] as  [4];
    logic [31:0] bs  [4];
    logic [31:0] exp [4];
    ops = '{OP_ADD, OP_XOR, OP_AND, OP_NOT};
    as  = '{32'h1, 32'h0000_F0F0, 32'hFF00_FF00, 32'h0};
    bs  = '{32'h2, 32'h0000_00FF, 32'h0FF0_0FF0, 32'h1234};
    exp = '{32'h3, 32'h0000_F00F, 32'h0F00_0F00, 32'hFFFF_FFFF};
    issue(4'd13, 32'h1234, 32'h5678, 4'd7);
    checks++;
    if (rsp_data !== 32'h0 || rsp_err !== 1'b1 || rsp_last !== 1'b1)
      $display("FAIL illegal: got d=%h err=%b last=%b want 0 1 1", rsp_data, rsp_err, rsp_last);
    else passed++;
    checks++; if (carry_flag !== 1'b1) $display("FAIL illegal_carry: got %b want 1", carry_flag); else passed++;
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_op = ops[i]; req_a = as[i]; req_b = bs[i]; req_tag = 4'(8 + i);
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_tag !== 4'(8 + i) || rsp_data !== exp[i] || rsp_err !== 1'b0)
        $display("FAIL b2b_%0d: got v=%b t=%0d d=%h e=%b want 1 %0d %h 0", i, rsp_valid, rsp_tag, rsp_data, rsp_err, 8 + i, exp[i]);
      else passed++;
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", rsp_valid); else passed++;
  endtask

  task automatic test_reset_mid_mul();
    rsp_ready = 1'b1;
    issue(OP_ADD, 32'hFFFF_FFFF, 32'h1, 4'd2);
    issue(OP_MUL, 32'h2, 32'h3, 4'd1);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_last !== 1'b1 || carry_flag !== 1'b1)
      $display("FAIL mid_mul_setup: got v=%b l=%b c=%b want 1 1 1", rsp_valid, rsp_last, carry_flag);
    else passed++;
    rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL mid_mul_valid: got %b want 0", rsp_valid); else passed++;
    checks++; if (carry_flag !== 1'b0) $display("FAIL mid_mul_carry: got %b want 0", carry_flag); else passed++;
    checks++; if (req_ready !== 1'b1) $display("FAIL mid_mul_idle: req_ready got %b want 1", req_ready); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b0) $display("FAIL mid_mul_no_beat: cycle %0d got %b want 0", i, rsp_valid); else passed++;
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_a = 32'd0; req_b = 32'd0;
    req_tag = 4'd0; rsp_ready = 1'b0; flag_clr = 1'b0;
    test_reset();
    test_add();
    test_adc_flag_clr();
    test_mul_backpressure();
    test_shifts();
    test_back_to_back();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
